// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial unsigned subtractor computing a - b - b_in.
// One bit is processed per clock, LSB first, through a single one-bit
// subtract stage. The result registers only change when a full operation
// completes, so partial differences never appear on diff.
// Optional feature: define SERSUB_OVF_EN to enable the registered
// two's-complement overflow flag; otherwise ovf is tied low.
module serial_subtractor #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             b_in,
  output logic [WIDTH-1:0] diff,
  output logic             b_out,
  output logic             busy,
  output logic             done,
  output logic             ovf
);

  // The counter must hold values 0..WIDTH without wrapping.
  localparam int CntW = $clog2(WIDTH + 1);
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } StateT;

  StateT            stateQ;
  logic [WIDTH-1:0] aQ;
  logic [WIDTH-1:0] bQ;
  logic             brwQ;
  logic [CntW-1:0]  cntQ;
  logic [WIDTH-1:0] diffQ;
  logic             bOutQ;
  logic             busyQ;
  logic             doneQ;

  logic             diffBitD;
  logic             brwD;
  logic             lastBit;

  // Single one-bit subtract stage fed by the LSBs of the operand shifters.
  always_comb begin
    diffBitD = aQ[0] ^ bQ[0] ^ brwQ;
    brwD     = (~aQ[0] & bQ[0]) | (~(aQ[0] ^ bQ[0]) & brwQ);
    lastBit  = (stateQ == SHIFT) && (cntQ == LastCnt);
  end

  // Control FSM, operand shifters and registered outputs. The minuend
  // shifter doubles as the difference accumulator: each difference bit
  // enters at the MSB as the consumed minuend bit leaves at the LSB.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stateQ <= IDLE;
      aQ     <= '0;
      bQ     <= '0;
      brwQ   <= 1'b0;
      cntQ   <= '0;
      diffQ  <= '0;
      bOutQ  <= 1'b0;
      busyQ  <= 1'b0;
      doneQ  <= 1'b0;
    end else begin
      case (stateQ)
        IDLE: begin
          doneQ <= 1'b0;
          if (start) begin
            aQ     <= a;
            bQ     <= b;
            brwQ   <= b_in;
            cntQ   <= '0;
            busyQ  <= 1'b1;
            stateQ <= SHIFT;
          end
        end
        SHIFT: begin
          aQ   <= {diffBitD, aQ[WIDTH-1:1]};
          bQ   <= {1'b0, bQ[WIDTH-1:1]};
          brwQ <= brwD;
          cntQ <= cntQ + CntW'(1);
          if (lastBit) begin
            diffQ  <= {diffBitD, aQ[WIDTH-1:1]};
            bOutQ  <= brwD;
            busyQ  <= 1'b0;
            doneQ  <= 1'b1;
            stateQ <= DONE;
          end
        end
        DONE: begin
          doneQ  <= 1'b0;
          stateQ <= IDLE;
        end
        default: begin
          busyQ  <= 1'b0;
          doneQ  <= 1'b0;
          stateQ <= IDLE;
        end
      endcase
    end
  end

  assign diff  = diffQ;
  assign b_out = bOutQ;
  assign busy  = busyQ;
  assign done  = doneQ;

`ifdef SERSUB_OVF_EN
  logic aMsbQ;
  logic bMsbQ;
  logic ovfQ;

  // Overflow flag: keep the operand sign bits from acceptance and judge the
  // final difference sign against them when the last bit is produced.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aMsbQ <= 1'b0;
      bMsbQ <= 1'b0;
      ovfQ  <= 1'b0;
    end else if ((stateQ == IDLE) && start) begin
      aMsbQ <= a[WIDTH-1];
      bMsbQ <= b[WIDTH-1];
    end else if (lastBit) begin
      ovfQ <= (aMsbQ != bMsbQ) && (diffBitD != aMsbQ);
    end
  end

  assign ovf = ovfQ;
`else
  assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: directed scoreboard bench for serial_subtractor.
// Stimulus pushes the hand-computed result and the cycle it must appear on;
// an independent monitor pops and compares on every done pulse.
module tb_serial_subtractor;

  localparam int WIDTH = 4;
`ifdef SERSUB_OVF_EN
  localparam bit OvfEn = 1'b1;
`else
  localparam bit OvfEn = 1'b0;
`endif

  typedef struct {
    logic [WIDTH-1:0] diff;
    logic             bOut;
    logic             ovf;
    int               cycle;
  } ExpT;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bIn;
  logic [WIDTH-1:0] diff;
  logic             bOut;
  logic             busy;
  logic             done;
  logic             ovf;

  ExpT              expQ[$];
  ExpT              monE;
  int               checks = 0;
  int               errors = 0;
  int               cycleCount = 0;
  logic [WIDTH-1:0] heldDiff;
  logic             heldBout;
  logic             heldOvf;

  serial_subtractor #(.WIDTH(WIDTH)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .start(start),
    .a    (a),
    .b    (b),
    .b_in (bIn),
    .diff (diff),
    .b_out(bOut),
    .busy (busy),
    .done (done),
    .ovf  (ovf)
  );

  // Free-running clock, 10 time units per period.
  always #5 clk = ~clk;

  // Rising-edge counter used to check result latency and throughput.
  always @(posedge clk) cycleCount <= cycleCount + 1;

  // One comparison; every mismatch prints a single FAIL line.
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Monitor: on each done pulse, pop the oldest expectation and compare.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && done === 1'b1) begin
      if (expQ.size() == 0) begin
        checkOutput("unexpected done", done, 0);
      end else begin
        monE = expQ.pop_front();
        checkOutput("diff", diff, monE.diff);
        checkOutput("b_out", bOut, monE.bOut);
        checkOutput("ovf", ovf, monE.ovf);
        checkOutput("done cycle", cycleCount, monE.cycle);
        heldDiff = monE.diff;
        heldBout = monE.bOut;
        heldOvf  = monE.ovf;
      end
    end
  end

  // Issue one operation and follow it through SHIFT and DONE. The operand
  // inputs are scrambled after acceptance; intrude selects a busy cycle
  // (0-based) at which a competing start request is raised.
  task automatic applyStimulus(input logic [WIDTH-1:0] aV, input logic [WIDTH-1:0] bV,
                               input logic binV, input logic [WIDTH-1:0] expDiff,
                               input logic expBout, input logic expOvf, input int intrude);
    ExpT e;
    @(posedge clk); #1;
    checkOutput("idle hold diff", diff, heldDiff);
    checkOutput("idle hold b_out", bOut, heldBout);
    checkOutput("idle hold ovf", ovf, heldOvf);
    checkOutput("idle busy", busy, 0);
    a = aV; b = bV; bIn = binV; start = 1'b1;
    e.diff = expDiff; e.bOut = expBout; e.ovf = expOvf & OvfEn;
    e.cycle = cycleCount + 1 + WIDTH;
    expQ.push_back(e);
    @(posedge clk); #1;
    start = 1'b0; a = ~aV; b = ~bV; bIn = ~binV;
    for (int i = 0; i < WIDTH; i++) begin
      checkOutput("busy in shift", busy, 1);
      checkOutput("diff stable in shift", diff, heldDiff);
      checkOutput("done low in shift", done, 0);
      if (i == intrude) begin
        start = 1'b1; a = 4'd1; b = 4'd1;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
    checkOutput("busy in done", busy, 0);
    checkOutput("done pulse", done, 1);
    @(posedge clk); #1;
    checkOutput("done one cycle", done, 0);
    checkOutput("busy after done", busy, 0);
  endtask

  // Wait, with a bound, for every queued expectation to be consumed.
  task automatic waitDrain();
    for (int i = 0; i < 60 && expQ.size() > 0; i++) @(posedge clk);
    if (expQ.size() > 0) begin
      checkOutput("result timeout", expQ.size(), 0);
      expQ.delete();
    end
  endtask

  // Abort an operation with reset in its third SHIFT cycle.
  task automatic applyResetMidShift();
    ExpT e;
    @(posedge clk); #1;
    a = 4'd10; b = 4'd3; bIn = 1'b1; start = 1'b1;
    e.diff = 4'd6; e.bOut = 1'b0; e.ovf = OvfEn; e.cycle = cycleCount + 1 + WIDTH;
    expQ.push_back(e);
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    expQ.delete();
    heldDiff = '0; heldBout = 1'b0; heldOvf = 1'b0;
    #1;
    checkOutput("reset diff", diff, 0);
    checkOutput("reset b_out", bOut, 0);
    checkOutput("reset busy", busy, 0);
    checkOutput("reset done", done, 0);
    checkOutput("reset ovf", ovf, 0);
    @(posedge clk); #2;
    rst_n = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    checkOutput("no done after abort", done, 0);
    checkOutput("diff cleared after abort", diff, 0);
  endtask

  // Hold start high: results must arrive every WIDTH+2 cycles.
  task automatic applyHeldStart();
    ExpT e;
    int  base;
    @(posedge clk); #1;
    a = 4'd5; b = 4'd5; bIn = 1'b0; start = 1'b1;
    base = cycleCount + 1;
    for (int k = 0; k < 3; k++) begin
      e.diff = 4'd0; e.bOut = 1'b0; e.ovf = 1'b0;
      e.cycle = base + WIDTH + k * (WIDTH + 2);
      expQ.push_back(e);
    end
    do begin
      @(posedge clk); #1;
    end while (cycleCount < base + 2 * (WIDTH + 2));
    start = 1'b0;
    waitDrain();
    @(posedge clk); #1;
  endtask

  // Safety net so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Main directed sequence.
  initial begin
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; bIn = 1'b0;
    heldDiff = '0; heldBout = 1'b0; heldOvf = 1'b0;
    #2;
    checkOutput("por diff", diff, 0);
    checkOutput("por b_out", bOut, 0);
    checkOutput("por busy", busy, 0);
    checkOutput("por done", done, 0);
    checkOutput("por ovf", ovf, 0);
    @(posedge clk); #2;
    rst_n = 1'b1;

    applyStimulus(4'd7,  4'd3,  1'b0, 4'd4,  1'b0, 1'b0, -1);
    applyStimulus(4'd3,  4'd7,  1'b0, 4'd12, 1'b1, 1'b0, -1);
    applyStimulus(4'd0,  4'd0,  1'b1, 4'd15, 1'b1, 1'b0, -1);
    applyStimulus(4'd8,  4'd1,  1'b0, 4'd7,  1'b0, 1'b1, -1);
    applyStimulus(4'd15, 4'd15, 1'b1, 4'd15, 1'b1, 1'b0, -1);
    applyStimulus(4'd4,  4'd12, 1'b0, 4'd8,  1'b1, 1'b1, -1);
    applyStimulus(4'd2,  4'd2,  1'b1, 4'd15, 1'b1, 1'b0, -1);
    applyStimulus(4'd9,  4'd2,  1'b0, 4'd7,  1'b0, 1'b1, 1);
    repeat (8) @(posedge clk);
    waitDrain();

    applyResetMidShift();
    applyStimulus(4'd4,  4'd12, 1'b0, 4'd8,  1'b1, 1'b1, -1);

    applyHeldStart();
    applyStimulus(4'd10, 4'd3,  1'b1, 4'd6,  1'b0, 1'b1, -1);
    repeat (6) @(posedge clk);
    waitDrain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
